// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory initiator: request ops, FSM states,
// and the small decode helpers used at request acceptance.
package mem_access_pkg;

    localparam int AW_DEF = 10;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WR     = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    function automatic logic is_store(op_t op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic misaligned(op_t op, logic [1:0] lane);
        case (op)
            OP_LW, OP_SW:         return lane != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lane[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response bundle; the pipeline is master, the controller is slave.
interface mem_access_ctrl_if;
    import mem_access_pkg::*;

    logic        req_valid;
    logic        req_ready;
    op_t         req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        addr_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, addr_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, addr_err
    );

endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Byte/halfword lane handling: load extract with sign/zero extension, and sub-word
// store merge into the word read back during read-modify-write.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  op_t         op,
    input  logic [1:0]  lane,
    input  logic [31:0] dm_word,
    input  logic [31:0] merge_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = dm_word[{lane, 3'b000} +: 8];
        half_sel = dm_word[{lane[1], 4'b0000} +: 16];

        load_data = dm_word;
        case (op)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0, half_sel};
            default: load_data = dm_word;
        endcase

        store_data = wdata;
        case (op)
            OP_SB: begin
                store_data = merge_word;
                store_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            OP_SH: begin
                store_data = merge_word;
                store_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for a word-only data memory: loads, full-word stores and
// read-modify-write sub-word stores, with alignment/range faults reported on the response.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_IDLE   | ready for a request; faults go straight to ST_RESP
//  ST_RD     | DM word addressed, extended lane registered into resp_rdata
//  ST_RMW_RD | DM word captured into the merge buffer for a sub-word store
//  ST_WR     | dm_we high, full or merged word driven to DM
//  ST_RESP   | resp_valid pulse, back to ST_IDLE
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic                clk,
    input  logic                reset,
    mem_access_ctrl_if.slave    bus,
    output logic [AW-1:0]       dm_addr,
    output logic [31:0]         dm_wdata,
    output logic                dm_we,
    input  logic [31:0]         dm_rdata
);

    state_t        state_q, state_d;
    op_t           op_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   merge_q;
    logic [31:0]   resp_rdata_q;
    logic          addr_err_q;

    logic          accept;
    logic          fault_now;
    logic [31:0]   load_data;
    logic [31:0]   store_data;

    assign fault_now = misaligned(bus.req_op, bus.req_addr[1:0]) || (|bus.req_addr[31:AW+2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // dm_we and dm_wdata come from state alone so an async reset kills the write at once.
    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        dm_we          = 1'b0;
        dm_wdata       = '0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                accept        = bus.req_valid;
                if (bus.req_valid) begin
                    if (fault_now)                state_d = ST_RESP;
                    else if (!is_store(bus.req_op)) state_d = ST_RD;
                    else if (bus.req_op == OP_SW) state_d = ST_WR;
                    else                          state_d = ST_RMW_RD;
                end
            end
            ST_RD:     state_d = ST_RESP;
            ST_RMW_RD: state_d = ST_WR;
            ST_WR: begin
                dm_we    = 1'b1;
                dm_wdata = store_data;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q         <= OP_LW;
            addr_q       <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            resp_rdata_q <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= bus.req_op;
                addr_q  <= bus.req_addr[AW+1:0];
                wdata_q <= bus.req_wdata;
                if (fault_now) begin
                    resp_rdata_q <= '0;
                    addr_err_q   <= 1'b1;
                end
            end
            case (state_q)
                ST_RD: begin
                    resp_rdata_q <= load_data;
                    addr_err_q   <= 1'b0;
                end
                ST_RMW_RD: merge_q <= dm_rdata;
                ST_WR: begin
                    resp_rdata_q <= '0;
                    addr_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    mem_lane_align u_align (
        .op         (op_q),
        .lane       (addr_q[1:0]),
        .dm_word    (dm_rdata),
        .merge_word (merge_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    assign dm_addr        = addr_q[AW+1:2];
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural DM, request driver, and a response scoreboard
// checking data, error flag and latency in cycles from the accept edge.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_we;

    logic [31:0] dm [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int   cyc = 0;
    int   we_cnt = 0;
    int   last_we = 0;
    int   last_acc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq[$];

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.AW(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_we    (dm_we),
        .dm_rdata (dm_rdata)
    );

    always #5 clk = ~clk;

    assign dm_rdata = dm[dm_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dm_we) begin
            dm[dm_addr] <= dm_wdata;
            we_cnt      <= we_cnt + 1;
        end else if (pl_en) begin
            dm[pl_addr] <= pl_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Edge index at which a signal seen at this negedge gets sampled is cyc+1.
    always @(negedge clk) begin
        if (!reset && dm_we) last_we = cyc + 1;
        if (!reset && bus.resp_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("addr_err", {31'd0, bus.addr_err}, {31'd0, e.err});
                check("latency", cyc + 1 - e.acc, e.lat);
            end
        end
    end

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input op_t op, input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] exp_d, input logic exp_e, input int lat,
                         input bit keep, output int waits);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = w;
        waits = 0;
        while (!bus.req_ready && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        last_acc = cyc;
        e.rdata = exp_d; e.err = exp_e; e.acc = cyc; e.lat = lat;
        sbq.push_back(e);
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", sbq.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int          w;
        int          we0;
        logic [31:0] word;
        logic [31:0] expw;
        logic [7:0]  b;

        bus.req_valid = 1'b0;
        bus.req_op    = OP_LW;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 1024; i++) dm[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_dm_we", {31'd0, dm_we}, 32'd0);
        check("rst_dm_addr", {22'd0, dm_addr}, 32'd0);
        check("rst_dm_wdata", dm_wdata, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Loads from DM[3]
        word = 32'h8899AABB;
        preload(10'd3, word);
        for (int k = 0; k < 4; k++) begin
            b = 8'(word >> (8 * k));
            issue(OP_LB,  32'h0C + k, 32'h0, {{24{b[7]}}, b}, 1'b0, 2, 1'b0, w);
            issue(OP_LBU, 32'h0C + k, 32'h0, {24'h0, b},      1'b0, 2, 1'b0, w);
        end
        issue(OP_LH,  32'h0E, 32'h0, 32'hFFFF8899, 1'b0, 2, 1'b0, w);
        issue(OP_LHU, 32'h0E, 32'h0, 32'h00008899, 1'b0, 2, 1'b0, w);
        issue(OP_LH,  32'h0C, 32'h0, 32'hFFFFAABB, 1'b0, 2, 1'b0, w);
        issue(OP_LW,  32'h0C, 32'h0, 32'h8899AABB, 1'b0, 2, 1'b0, w);
        drain();

        // Sub-word stores into DM[5]
        preload(10'd5, 32'h11223344);
        we0 = we_cnt;
        issue(OP_SB, 32'h15, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1'b0, w);
        drain();
        check("sb_dm5", dm[5], 32'h1122EF44);
        check("sb_we_count", we_cnt - we0, 1);
        check("sb_we_edge", last_we - last_acc, 2);
        issue(OP_SH, 32'h16, 32'h0000CAFE, 32'h0, 1'b0, 3, 1'b0, w);
        drain();
        check("sh_dm5", dm[5], 32'hCAFEEF44);
        check("sh_we_count", we_cnt - we0, 2);

        // SB across all lanes of DM[16]
        preload(10'd16, 32'hA5A5A5A5);
        expw = 32'hA5A5A5A5;
        for (int k = 0; k < 4; k++) begin
            b = 8'(8'h10 * k + 8'h03);
            expw = (expw & ~(32'hFF << (8 * k))) | ({24'h0, b} << (8 * k));
            issue(OP_SB, 32'h40 + k, {24'hFFFFFF, b}, 32'h0, 1'b0, 3, 1'b0, w);
            drain();
            check("sb_lane_dm16", dm[16], expw);
        end

        // Faults
        we0 = we_cnt;
        issue(OP_LW,  32'h0000000D, 32'h0,        32'h0, 1'b1, 1, 1'b0, w);
        issue(OP_SH,  32'h00000011, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b0, w);
        issue(OP_SW,  32'h00001000, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b0, w);
        issue(OP_LHU, 32'h0000000F, 32'h0,        32'h0, 1'b1, 1, 1'b0, w);
        issue(OP_SB,  32'h80000004, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b0, w);
        drain();
        check("fault_no_write", we_cnt - we0, 0);
        check("fault_dm5_kept", dm[5], 32'hCAFEEF44);

        // Back-to-back with req_valid held
        issue(OP_SW, 32'h20, 32'h12345678, 32'h0, 1'b0, 2, 1'b1, w);
        issue(OP_LW, 32'h20, 32'h0, 32'h12345678, 1'b0, 2, 1'b0, w);
        check("b2b_ready_low_cycles", w, 2);
        drain();
        check("sw_dm8", dm[8], 32'h12345678);

        // Reset during the WR phase of an SB
        preload(10'd12, 32'h55667788);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SB;
        bus.req_addr  = 32'h30;
        bus.req_wdata = 32'h000000EE;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        w = 0;
        while (!dm_we && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        check("rst6_reached_wr", {31'd0, dm_we}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst6_dm_we", {31'd0, dm_we}, 32'd0);
        check("rst6_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst6_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst6_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst6_addr_err", {31'd0, bus.addr_err}, 32'd0);
        check("rst6_dm_addr", {22'd0, dm_addr}, 32'd0);
        check("rst6_dm_wdata", dm_wdata, 32'd0);
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("rst6_ready_after", {31'd0, bus.req_ready}, 32'd1);
        check("rst6_dm12_kept", dm[12], 32'h55667788);
        issue(OP_LW, 32'h30, 32'h0, 32'h55667788, 1'b0, 2, 1'b0, w);
        drain();

        check("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
